// File: rtl/enc_layer_mvm.sv
// Encoder-layer matrix-vector engine: y = W*x in signed fixed point, with optional ReLU.
// Weights come from an external synchronous ROM. The MAC stage runs one cycle behind the address.
module enc_layer_mvm #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int RELU   = 0,
  localparam int N     = N_IN * N_OUT,
  localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_IN*DATA_W-1:0]    x_in,
  output logic [AW-1:0]             w_addr,
  output logic                      w_rd_en,
  input  logic [DATA_W-1:0]         w_data,
  output logic [N_OUT*DATA_W-1:0]   y_out,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                state;
  logic [RW-1:0]             row, row_d;
  logic [CW-1:0]             col, col_d;
  logic                      valid_d;
  logic [N_IN*DATA_W-1:0]    x_reg;
  logic signed [ACC_W-1:0]   acc;

  logic signed [DATA_W-1:0]   x_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]          res;

  assign w_rd_en = (state == RUN);
  assign w_addr  = AW'(row * N_IN + col);

  assign x_sel   = x_reg[col_d*DATA_W +: DATA_W];
  assign prod    = $signed(w_data) * x_sel;
  assign sum     = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign shifted = sum >>> FRAC;

  // Saturate the closed row to DATA_W, then optionally clamp negatives
  always_comb begin
    res = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = shifted[DATA_W-1:0];
    end
    if ((RELU != 0) && res[DATA_W-1]) begin
      res = '0;
    end else begin
      res = res;
    end
  end

  // Control FSM, address counters, delayed MAC stage and result write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      row_d   <= '0;
      col_d   <= '0;
      valid_d <= 1'b0;
      x_reg   <= '0;
      acc     <= '0;
      y_out   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      valid_d <= (state == RUN);
      row_d   <= row;
      col_d   <= col;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= x_in;
            row   <= '0;
            col   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= DRAIN;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Row close writes the result and restarts the accumulator without a bubble
      if (valid_d) begin
        if (col_d == COL_LAST) begin
          y_out[row_d*DATA_W +: DATA_W] <= res;
          acc <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule
